// File: rtl/rob_alloc_pkg.sv
// Shared types for the dispatch-side ROB allocator.
package rob_alloc_pkg;

    localparam int ROB_DEPTH = 16;
    localparam int ROB_IDX_W = $clog2(ROB_DEPTH);

    typedef struct packed {
        logic regWrite;
        logic memToReg;
        logic memWrite;
        logic branch;
    } controlStruct;

    typedef struct packed {
        logic         valid;
        logic [31:0]  pc;
        logic [5:0]   rd;
        logic [5:0]   rd_old;
        controlStruct control;
    } renamedInstrStruct;

    typedef struct packed {
        logic                 valid;
        logic [31:0]          pc;
        logic [5:0]           rd;
        logic [5:0]           rd_old;
        controlStruct         control;
        logic [ROB_IDX_W-1:0] robNum;
    } robDispatchStruct;

endpackage

// File: rtl/rob_occupancy_ctr.sv
// ROB occupancy tracker: mirrors the retire pointer and keeps the free-entry count.
module rob_occupancy_ctr #(
    parameter int ROB_DEPTH = 16,
    parameter int IDX_W     = $clog2(ROB_DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       alloc_cnt,
    input  logic [1:0]       retire_cnt,
    input  logic [IDX_W-1:0] tail,
    output logic [IDX_W-1:0] head,
    output logic [IDX_W:0]   free
);

    localparam int unsigned    FREE_MAX_I = ROB_DEPTH;
    localparam logic [IDX_W:0] FREE_MAX   = FREE_MAX_I[IDX_W:0];

    logic [IDX_W-1:0] head_q, head_d;
    logic [IDX_W:0]   free_q, free_d;

    // Next state: both allocation and retirement of the same cycle apply together.
    always_comb begin
        head_d = head_q + {{(IDX_W-2){1'b0}}, retire_cnt};
        free_d = free_q - {{(IDX_W-1){1'b0}}, alloc_cnt}
                        + {{(IDX_W-1){1'b0}}, retire_cnt};
    end

    // Pointer and count registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head_q <= '0;
            free_q <= FREE_MAX;
        end else begin
            head_q <= head_d;
            free_q <= free_d;
        end
    end

    assign head = head_q;
    assign free = free_q;

    // Occupied entries seen by the pointers must match the count; full aliases tail==head.
    logic [IDX_W-1:0] ptr_diff;
    logic [IDX_W:0]   used;
    assign ptr_diff = tail - head_q;
    assign used     = FREE_MAX - free_q;

    a_ptr_vs_count: assert property (@(posedge clk) disable iff (!reset_n)
        used == ((free_q == '0) ? FREE_MAX : {1'b0, ptr_diff}));

    a_no_retire_empty: assert property (@(posedge clk) disable iff (!reset_n)
        (free_q == FREE_MAX) |-> (retire_cnt == 2'd0));

endmodule

// File: rtl/rob_alloc.sv
// Two-wide ROB index allocator: stamps renamed instructions and registers them toward the ROB.
module rob_alloc
    import rob_alloc_pkg::*;
#(
    parameter int ROB_DEPTH = rob_alloc_pkg::ROB_DEPTH,
    parameter int IDX_W     = $clog2(ROB_DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  renamedInstrStruct instr_a,
    input  renamedInstrStruct instr_b,
    output logic              in_ready,
    input  logic              retire_a_valid,
    input  logic              retire_b_valid,
    output robDispatchStruct  robDispatch_a,
    output robDispatchStruct  robDispatch_b,
    output logic [IDX_W:0]    free_count,
    output logic [IDX_W-1:0]  head_ptr,
    output logic [IDX_W-1:0]  tail_ptr
);

    logic [IDX_W-1:0] tail_q, tail_d, tail_p1;
    logic             acc_a, acc_b;
    logic [1:0]       alloc_cnt, retire_cnt;
    robDispatchStruct disp_a_q, disp_a_d, disp_b_q, disp_b_d;

    // Ready depends only on the registered count; a lone free entry is never handed out.
    assign in_ready   = (free_count >= 2);
    assign acc_a      = in_ready & instr_a.valid;
    // b without a is a rename protocol violation and allocates nothing.
    assign acc_b      = in_ready & instr_a.valid & instr_b.valid;
    assign alloc_cnt  = {1'b0, acc_a} + {1'b0, acc_b};
    assign retire_cnt = {1'b0, retire_a_valid} + {1'b0, retire_b_valid};
    assign tail_p1    = tail_q + 1'b1;

    // Dispatch payload: indices stay tail/tail+1 even for invalid slots so they never collide.
    always_comb begin
        tail_d           = tail_q + {{(IDX_W-2){1'b0}}, alloc_cnt};
        disp_a_d         = '0;
        disp_a_d.valid   = acc_a;
        disp_a_d.pc      = instr_a.pc;
        disp_a_d.rd      = instr_a.rd;
        disp_a_d.rd_old  = instr_a.rd_old;
        disp_a_d.control = instr_a.control;
        disp_a_d.robNum  = tail_q;
        disp_b_d         = '0;
        disp_b_d.valid   = acc_b;
        disp_b_d.pc      = instr_b.pc;
        disp_b_d.rd      = instr_b.rd;
        disp_b_d.rd_old  = instr_b.rd_old;
        disp_b_d.control = instr_b.control;
        disp_b_d.robNum  = tail_p1;
    end

    // Tail and output registers; reset drops any in-flight allocation.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tail_q          <= '0;
            disp_a_q        <= '0;
            disp_b_q        <= '0;
            disp_b_q.robNum <= {{(IDX_W-1){1'b0}}, 1'b1};
        end else begin
            tail_q   <= tail_d;
            disp_a_q <= disp_a_d;
            disp_b_q <= disp_b_d;
        end
    end

    rob_occupancy_ctr #(
        .ROB_DEPTH (ROB_DEPTH),
        .IDX_W     (IDX_W)
    ) u_occ (
        .clk        (clk),
        .reset_n    (reset_n),
        .alloc_cnt  (alloc_cnt),
        .retire_cnt (retire_cnt),
        .tail       (tail_q),
        .head       (head_ptr),
        .free       (free_count)
    );

    assign robDispatch_a = disp_a_q;
    assign robDispatch_b = disp_b_q;
    assign tail_ptr      = tail_q;

endmodule

// File: tb/tb_rob_alloc.sv
// Directed bench for rob_alloc: reset, fill, single slot, simultaneous events, wrap, mid-stream reset.
module tb_rob_alloc;
    import rob_alloc_pkg::*;

    logic              clk = 1'b0;
    logic              reset_n;
    renamedInstrStruct instr_a, instr_b;
    logic              in_ready;
    logic              retire_a_valid, retire_b_valid;
    robDispatchStruct  robDispatch_a, robDispatch_b;
    logic [4:0]        free_count;
    logic [3:0]        head_ptr, tail_ptr;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    rob_alloc dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .instr_a        (instr_a),
        .instr_b        (instr_b),
        .in_ready       (in_ready),
        .retire_a_valid (retire_a_valid),
        .retire_b_valid (retire_b_valid),
        .robDispatch_a  (robDispatch_a),
        .robDispatch_b  (robDispatch_b),
        .free_count     (free_count),
        .head_ptr       (head_ptr),
        .tail_ptr       (tail_ptr)
    );

    // One clock, leaving the bench at the falling edge for checks and new stimulus.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic va, input logic vb, input logic ra, input logic rb);
        instr_a        = '{valid: va, pc: 32'h100, rd: 6'd5, rd_old: 6'd7, control: 4'b1010};
        instr_b        = '{valid: vb, pc: 32'h104, rd: 6'd6, rd_old: 6'd8, control: 4'b0101};
        retire_a_valid = ra;
        retire_b_valid = rb;
    endtask

    task automatic do_reset(input int cycles);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b0;
        repeat (cycles) step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(2);
        vectors++; if (free_count !== 5'd16) begin miscompares++; $display("FAIL reset_free: got %0d want 16", free_count); end
        vectors++; if (tail_ptr !== 4'd0) begin miscompares++; $display("FAIL reset_tail: got %0d want 0", tail_ptr); end
        vectors++; if (head_ptr !== 4'd0) begin miscompares++; $display("FAIL reset_head: got %0d want 0", head_ptr); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        vectors++; if (robDispatch_a !== '0) begin miscompares++; $display("FAIL reset_disp_a: got %h want 0", robDispatch_a); end
        vectors++; if (robDispatch_b.valid !== 1'b0 || robDispatch_b.pc !== 32'h0 || robDispatch_b.robNum !== 4'd1) begin
            miscompares++; $display("FAIL reset_disp_b: got v=%b pc=%h num=%0d want v=0 pc=0 num=1",
                robDispatch_b.valid, robDispatch_b.pc, robDispatch_b.robNum); end
    endtask

    task automatic test_steady_fill();
        logic [3:0] ea, eb;
        logic [4:0] ef;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0);
            step();
            ea = 4'(2 * i); eb = 4'(2 * i + 1); ef = 5'(16 - 2 * (i + 1));
            vectors++; if (robDispatch_a.valid !== 1'b1 || robDispatch_a.robNum !== ea || robDispatch_a.pc !== 32'h100) begin
                miscompares++; $display("FAIL fill_a[%0d]: got v=%b num=%0d pc=%h want v=1 num=%0d pc=100",
                    i, robDispatch_a.valid, robDispatch_a.robNum, robDispatch_a.pc, ea); end
            vectors++; if (robDispatch_b.valid !== 1'b1 || robDispatch_b.robNum !== eb || robDispatch_b.pc !== 32'h104) begin
                miscompares++; $display("FAIL fill_b[%0d]: got v=%b num=%0d pc=%h want v=1 num=%0d pc=104",
                    i, robDispatch_b.valid, robDispatch_b.robNum, robDispatch_b.pc, eb); end
            vectors++; if (free_count !== ef) begin miscompares++; $display("FAIL fill_free[%0d]: got %0d want %0d", i, free_count, ef); end
        end
        vectors++; if (robDispatch_a.rd !== 6'd5 || robDispatch_a.rd_old !== 6'd7 || robDispatch_a.control !== 4'b1010) begin
            miscompares++; $display("FAIL fill_fields_a: got rd=%0d old=%0d ctl=%b want 5 7 1010",
                robDispatch_a.rd, robDispatch_a.rd_old, robDispatch_a.control); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL fill_full_ready: got %b want 0", in_ready); end
        // Ninth pair is held back.
        step();
        vectors++; if (robDispatch_a.valid !== 1'b0 || robDispatch_b.valid !== 1'b0) begin
            miscompares++; $display("FAIL fill_held: got va=%b vb=%b want 0 0", robDispatch_a.valid, robDispatch_b.valid); end
        vectors++; if (tail_ptr !== 4'd0 || free_count !== 5'd0) begin
            miscompares++; $display("FAIL fill_held_state: got tail=%0d free=%0d want 0 0", tail_ptr, free_count); end
        // Drain everything.
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1);
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        vectors++; if (free_count !== 5'd16 || head_ptr !== 4'd0) begin
            miscompares++; $display("FAIL drain: got free=%0d head=%0d want 16 0", free_count, head_ptr); end
    endtask

    task automatic test_single_a();
        drive(1'b1, 1'b1, 1'b0, 1'b0); step();
        drive(1'b1, 1'b0, 1'b0, 1'b0); step();
        vectors++; if (tail_ptr !== 4'd3 || free_count !== 5'd13) begin
            miscompares++; $display("FAIL single_setup: got tail=%0d free=%0d want 3 13", tail_ptr, free_count); end
        drive(1'b1, 1'b0, 1'b0, 1'b0); step();
        vectors++; if (robDispatch_a.valid !== 1'b1 || robDispatch_a.robNum !== 4'd3) begin
            miscompares++; $display("FAIL single_a: got v=%b num=%0d want 1 3", robDispatch_a.valid, robDispatch_a.robNum); end
        vectors++; if (robDispatch_b.valid !== 1'b0 || robDispatch_b.robNum !== 4'd4) begin
            miscompares++; $display("FAIL single_b: got v=%b num=%0d want 0 4", robDispatch_b.valid, robDispatch_b.robNum); end
        vectors++; if (tail_ptr !== 4'd4 || free_count !== 5'd12) begin
            miscompares++; $display("FAIL single_state: got tail=%0d free=%0d want 4 12", tail_ptr, free_count); end
        // b without a allocates nothing.
        drive(1'b0, 1'b1, 1'b0, 1'b0); step();
        vectors++; if (robDispatch_a.valid !== 1'b0 || robDispatch_b.valid !== 1'b0 || tail_ptr !== 4'd4 || free_count !== 5'd12) begin
            miscompares++; $display("FAIL b_only: got va=%b vb=%b tail=%0d free=%0d want 0 0 4 12",
                robDispatch_a.valid, robDispatch_b.valid, tail_ptr, free_count); end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0); step();
        end
        vectors++; if (free_count !== 5'd4 || tail_ptr !== 4'd12) begin
            miscompares++; $display("FAIL simul_setup: got free=%0d tail=%0d want 4 12", free_count, tail_ptr); end
        drive(1'b1, 1'b1, 1'b1, 1'b1); step();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        vectors++; if (free_count !== 5'd4 || head_ptr !== 4'd2 || tail_ptr !== 4'd14) begin
            miscompares++; $display("FAIL simul: got free=%0d head=%0d tail=%0d want 4 2 14", free_count, head_ptr, tail_ptr); end
        vectors++; if (robDispatch_a.robNum !== 4'd12 || robDispatch_b.robNum !== 4'd13 || robDispatch_b.valid !== 1'b1) begin
            miscompares++; $display("FAIL simul_nums: got %0d/%0d vb=%b want 12/13 1",
                robDispatch_a.robNum, robDispatch_b.robNum, robDispatch_b.valid); end
    endtask

    task automatic test_wrap_credit();
        do_reset(1);
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0); step();
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0); step();
        // One free entry left: not usable.
        vectors++; if (in_ready !== 1'b0 || free_count !== 5'd1 || tail_ptr !== 4'd15) begin
            miscompares++; $display("FAIL wrap_one_free: got rdy=%b free=%0d tail=%0d want 0 1 15", in_ready, free_count, tail_ptr); end
        drive(1'b0, 1'b0, 1'b1, 1'b0); step();
        vectors++; if (in_ready !== 1'b1 || free_count !== 5'd2 || head_ptr !== 4'd1) begin
            miscompares++; $display("FAIL wrap_setup: got rdy=%b free=%0d head=%0d want 1 2 1", in_ready, free_count, head_ptr); end
        drive(1'b1, 1'b1, 1'b0, 1'b0); step();
        vectors++; if (robDispatch_a.robNum !== 4'd15 || robDispatch_b.robNum !== 4'd0 || robDispatch_a.valid !== 1'b1 || robDispatch_b.valid !== 1'b1) begin
            miscompares++; $display("FAIL wrap_nums: got %0d/%0d v=%b%b want 15/0 v=11",
                robDispatch_a.robNum, robDispatch_b.robNum, robDispatch_a.valid, robDispatch_b.valid); end
        vectors++; if (in_ready !== 1'b0 || free_count !== 5'd0 || tail_ptr !== 4'd1) begin
            miscompares++; $display("FAIL wrap_full: got rdy=%b free=%0d tail=%0d want 0 0 1", in_ready, free_count, tail_ptr); end
        drive(1'b0, 1'b0, 1'b1, 1'b0); step();
        vectors++; if (in_ready !== 1'b0 || free_count !== 5'd1) begin
            miscompares++; $display("FAIL credit_a: got rdy=%b free=%0d want 0 1", in_ready, free_count); end
        drive(1'b0, 1'b0, 1'b0, 1'b1); step();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        vectors++; if (in_ready !== 1'b1 || free_count !== 5'd2 || head_ptr !== 4'd3) begin
            miscompares++; $display("FAIL credit_b: got rdy=%b free=%0d head=%0d want 1 2 3", in_ready, free_count, head_ptr); end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b0, 1'b1, 1'b1); step();
        drive(1'b0, 1'b0, 1'b1, 1'b0); step();
        vectors++; if (free_count !== 5'd5 || in_ready !== 1'b1) begin
            miscompares++; $display("FAIL mid_setup: got free=%0d rdy=%b want 5 1", free_count, in_ready); end
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        reset_n = 1'b0;
        step();
        vectors++; if (robDispatch_a.valid !== 1'b0 || robDispatch_b.valid !== 1'b0 || robDispatch_b.robNum !== 4'd1 || robDispatch_a.robNum !== 4'd0) begin
            miscompares++; $display("FAIL mid_disp: got v=%b%b nums=%0d/%0d want v=00 nums=0/1",
                robDispatch_a.valid, robDispatch_b.valid, robDispatch_a.robNum, robDispatch_b.robNum); end
        vectors++; if (free_count !== 5'd16 || tail_ptr !== 4'd0 || head_ptr !== 4'd0) begin
            miscompares++; $display("FAIL mid_state: got free=%0d tail=%0d head=%0d want 16 0 0", free_count, tail_ptr, head_ptr); end
        reset_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        step();
        vectors++; if (free_count !== 5'd16 || in_ready !== 1'b1 || tail_ptr !== 4'd0) begin
            miscompares++; $display("FAIL mid_after: got free=%0d rdy=%b tail=%0d want 16 1 0", free_count, in_ready, tail_ptr); end
    endtask

    initial begin
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        test_reset();
        test_steady_fill();
        test_single_a();
        test_simultaneous();
        test_wrap_credit();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
